wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage of the 5-stage in-order core; sits between the MEM stage and the 32-entry register file, which it drives through a single write port.
- Captures MEM results on a valid/allowin handshake and aligns/extends load data from the synchronous data SRAM.
- Drives the register-file write port and exports forwarding info to decode.

Parameters:
DATA_W, 32, datapath width
RADDR_W, 5, register address width

Ports:
clk  in  1  core clock
resetn  in  1  synchronous active-low reset
mem_to_wb_valid  in  1  MEM holds a valid instruction
wb_allowin  out  1  WB can accept this cycle
mem_pc  in  32  PC of MEM instruction
mem_reg_we  in  1  instruction writes a GPR
mem_reg_addr  in  RADDR_W  destination GPR
mem_alu_result  in  DATA_W  ALU result / effective address
mem_load_type  in  3  load kind, package encoding
data_sram_rdata  in  DATA_W  SRAM read data, valid in the cycle the load occupies WB
wb_stall  in  1  external hold (debug/exception unit)
wb_flush  in  1  cancel instruction held in WB
rf_w_en  out  1  register-file write enable
rf_w_addr  out  RADDR_W  register-file write address
rf_w_data  out  DATA_W  register-file write data
wb_fwd_valid  out  1  forwarding entry valid
wb_fwd_addr  out  RADDR_W  forwarding destination
wb_fwd_data  out  DATA_W  forwarding data, equal to rf_w_data

Behaviour:
- Reset, synchronous on resetn=0 at posedge clk:
  - wb_valid=0 and all captured fields=0.
  - Consequently rf_w_en=0, wb_fwd_valid=0, rf_w_addr=0, rf_w_data=0.
- Handshake:
  - wb_ready_go = ~wb_stall.
  - wb_allowin = ~wb_valid | (wb_ready_go & ~wb_flush) | wb_flush.
  - Capture occurs when mem_to_wb_valid & wb_allowin. Next wb_valid = mem_to_wb_valid if wb_allowin, else it holds.
  - Fields are loaded only on capture.
- Flush: wb_flush=1 kills the held instruction this cycle, so rf_w_en=0. A simultaneous new capture is still accepted (flush affects only the current occupant).
- Write, combinational from registered state:
  - rf_w_en = wb_valid & wb_reg_we & ~wb_stall & ~wb_flush & (wb_reg_addr≠0).
  - This gives exactly one write per instruction, in its final WB cycle. While stalled, rf_w_en=0.
- Latency: an instruction accepted at edge N writes the register file during cycle N+1 (edge N+1 commits), provided there is no stall.
- Data select:
  - LD_NONE or unknown encoding → alu_result.
  - LD_LW → rdata.
  - LD_LB/LD_LBU → byte rdata[8*addr[1:0]+:8], sign-/zero-extended.
  - LD_LH/LD_LHU → halfword selected by addr[1]; addr[0] is ignored (alignment exceptions are raised upstream).
- Forwarding: wb_fwd_valid = wb_valid & wb_reg_we & (wb_reg_addr≠0), asserted regardless of stall. wb_fwd_addr/wb_fwd_data mirror the write port.
- Back-to-back: a new capture every cycle with no bubbles when wb_stall=0.
- Reset mid-stall: the instruction is discarded with no write.

Optional Feature:
- Macro: DEBUG_TRACE_EN.
- Defined: adds outputs debug_wb_pc[31:0], debug_wb_rf_wen[3:0] (= {4{rf_w_en}}), debug_wb_rf_wnum[4:0] and debug_wb_rf_wdata[31:0], all combinational from the write port. debug_wb_pc = captured PC. All are 0 in reset.
- Undefined: these ports and the PC register are absent; the remaining behaviour is identical.

Decomposition:
- Shared defines header: LD_NONE=0, LD_LB=1, LD_LBU=2, LD_LH=3, LD_LHU=4, LD_LW=5; load-type bus width; existing data/reg-address bus macros.
- One combinational sub-module, load_align: inputs rdata, addr_low[1:0] and load_type; output extended word.

Test Plan:
- Reset: hold resetn=0 for 2 cycles while mem_to_wb_valid=1 → rf_w_en=0 and wb_allowin=1; after release, first capture writes in the next cycle.
- ALU write: mem_reg_addr=5, alu_result=0x1234_5678, LD_NONE → one cycle later rf_w_en=1, rf_w_addr=5, rf_w_data=0x12345678, wb_fwd_valid=1.
- Load extraction with rdata=0x80FF_7F01:
  - LB addr_low=3 → 0xFFFFFF80.
  - LBU addr_low=3 → 0x00000080.
  - LH addr_low=2 → 0xFFFF80FF.
  - LHU addr_low=0 → 0x00007F01.
  - LW → 0x80FF7F01.
- $0 target: mem_reg_addr=0, mem_reg_we=1 → rf_w_en=0 and wb_fwd_valid=0.
- Stall: wb_stall=1 for 3 cycles with the instruction held:
  - During the stall: wb_allowin=0, rf_w_en=0 and wb_fwd_valid=1.
  - On release: exactly one write.
  - The next MEM instruction is accepted only after release.
- Flush+capture: wb_flush=1 with a new valid in the same cycle → old instruction is not written; new instruction writes in the following cycle.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: bus widths and load-type encodings.
// The is_load helper separates memory results from ALU results.
package wb_stage_pkg;

  localparam int DATA_BUS_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int LD_TYPE_W  = 3;

  localparam logic [LD_TYPE_W-1:0] LD_NONE = 3'd0;
  localparam logic [LD_TYPE_W-1:0] LD_LB   = 3'd1;
  localparam logic [LD_TYPE_W-1:0] LD_LBU  = 3'd2;
  localparam logic [LD_TYPE_W-1:0] LD_LH   = 3'd3;
  localparam logic [LD_TYPE_W-1:0] LD_LHU  = 3'd4;
  localparam logic [LD_TYPE_W-1:0] LD_LW   = 3'd5;

  function automatic logic is_load(input logic [LD_TYPE_W-1:0] lt);
    return (lt >= LD_LB) && (lt <= LD_LW);
  endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Load aligner: picks the byte/halfword/word addressed by addr_low and sign/zero extends it.
// Latency: combinational. Backpressure: none.
// Halfword selection ignores addr_low[0]; misalignment is trapped before this stage.
module wb_stage_load_align
  import wb_stage_pkg::*;
(
  input  logic [DATA_BUS_W-1:0] rdata,
  input  logic [1:0]            addr_low,
  input  logic [LD_TYPE_W-1:0]  load_type,
  output logic [DATA_BUS_W-1:0] load_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = rdata[{addr_low, 3'b000} +: 8];
    half_sel  = addr_low[1] ? rdata[31:16] : rdata[15:0];
    load_word = '0;
    case (load_type)
      LD_LB:   load_word = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  load_word = {24'd0, byte_sel};
      LD_LH:   load_word = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  load_word = {16'd0, half_sel};
      LD_LW:   load_word = rdata;
      default: load_word = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: captures MEM results, aligns load data, drives the regfile write port and forwarding.
// Latency: one cycle from capture to regfile write. Backpressure: wb_stall holds the occupant and drops wb_allowin.
// Optional DEBUG_TRACE_EN adds the debug_wb_* trace outputs and a captured PC register.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W  = DATA_BUS_W,
  parameter int RADDR_W = REG_ADDR_W
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 mem_to_wb_valid,
  output logic                 wb_allowin,
  input  logic [31:0]          mem_pc,
  input  logic                 mem_reg_we,
  input  logic [RADDR_W-1:0]   mem_reg_addr,
  input  logic [DATA_W-1:0]    mem_alu_result,
  input  logic [LD_TYPE_W-1:0] mem_load_type,
  input  logic [DATA_W-1:0]    data_sram_rdata,
  input  logic                 wb_stall,
  input  logic                 wb_flush,
  output logic                 rf_w_en,
  output logic [RADDR_W-1:0]   rf_w_addr,
  output logic [DATA_W-1:0]    rf_w_data,
  output logic                 wb_fwd_valid,
  output logic [RADDR_W-1:0]   wb_fwd_addr,
  output logic [DATA_W-1:0]    wb_fwd_data
`ifdef DEBUG_TRACE_EN
  ,
  output logic [31:0]          debug_wb_pc,
  output logic [3:0]           debug_wb_rf_wen,
  output logic [4:0]           debug_wb_rf_wnum,
  output logic [31:0]          debug_wb_rf_wdata
`endif
);

  logic                 wb_valid;
  logic                 wb_reg_we;
  logic [RADDR_W-1:0]   wb_reg_addr;
  logic [DATA_W-1:0]    wb_alu_result;
  logic [LD_TYPE_W-1:0] wb_load_type;
  logic                 wb_ready_go;
  logic                 capture;
  logic                 dest_live;
  logic [DATA_W-1:0]    load_word;

  assign wb_ready_go = ~wb_stall;
  // A flush frees the slot even while stalled, so a new instruction can slide in behind it.
  assign wb_allowin  = ~wb_valid | (wb_ready_go & ~wb_flush) | wb_flush;
  assign capture     = mem_to_wb_valid & wb_allowin;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wb_valid      <= 1'b0;
      wb_reg_we     <= 1'b0;
      wb_reg_addr   <= '0;
      wb_alu_result <= '0;
      wb_load_type  <= LD_NONE;
    end else begin
      if (wb_allowin) wb_valid <= mem_to_wb_valid;
      if (capture) begin
        wb_reg_we     <= mem_reg_we;
        wb_reg_addr   <= mem_reg_addr;
        wb_alu_result <= mem_alu_result;
        wb_load_type  <= mem_load_type;
      end
    end
  end

  wb_stage_load_align u_load_align (
    .rdata     (data_sram_rdata),
    .addr_low  (wb_alu_result[1:0]),
    .load_type (wb_load_type),
    .load_word (load_word)
  );

  assign dest_live    = wb_valid & wb_reg_we & (wb_reg_addr != '0);
  assign rf_w_en      = dest_live & ~wb_stall & ~wb_flush;
  assign rf_w_addr    = wb_reg_addr;
  assign rf_w_data    = is_load(wb_load_type) ? load_word : wb_alu_result;
  assign wb_fwd_valid = dest_live;
  assign wb_fwd_addr  = rf_w_addr;
  assign wb_fwd_data  = rf_w_data;

`ifdef DEBUG_TRACE_EN
  logic [31:0] wb_pc;

  always_ff @(posedge clk) begin
    if (!resetn)      wb_pc <= '0;
    else if (capture) wb_pc <= mem_pc;
  end

  assign debug_wb_pc       = wb_pc;
  assign debug_wb_rf_wen   = {4{rf_w_en}};
  assign debug_wb_rf_wnum  = rf_w_addr;
  assign debug_wb_rf_wdata = rf_w_data;
`else
  logic unused_pc;
  assign unused_pc = ^mem_pc;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, ALU/load writeback, $0, stall, flush, back-to-back, reset-in-stall.
// Inputs change 1ns after posedge clk; outputs are sampled 1ns later.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_to_wb_valid;
  logic        wb_allowin;
  logic [31:0] mem_pc;
  logic        mem_reg_we;
  logic [4:0]  mem_reg_addr;
  logic [31:0] mem_alu_result;
  logic [2:0]  mem_load_type;
  logic [31:0] data_sram_rdata;
  logic        wb_stall;
  logic        wb_flush;
  logic        rf_w_en;
  logic [4:0]  rf_w_addr;
  logic [31:0] rf_w_data;
  logic        wb_fwd_valid;
  logic [4:0]  wb_fwd_addr;
  logic [31:0] wb_fwd_data;
`ifdef DEBUG_TRACE_EN
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .mem_to_wb_valid (mem_to_wb_valid),
    .wb_allowin      (wb_allowin),
    .mem_pc          (mem_pc),
    .mem_reg_we      (mem_reg_we),
    .mem_reg_addr    (mem_reg_addr),
    .mem_alu_result  (mem_alu_result),
    .mem_load_type   (mem_load_type),
    .data_sram_rdata (data_sram_rdata),
    .wb_stall        (wb_stall),
    .wb_flush        (wb_flush),
    .rf_w_en         (rf_w_en),
    .rf_w_addr       (rf_w_addr),
    .rf_w_data       (rf_w_data),
    .wb_fwd_valid    (wb_fwd_valid),
    .wb_fwd_addr     (wb_fwd_addr),
    .wb_fwd_data     (wb_fwd_data)
`ifdef DEBUG_TRACE_EN
    ,
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] addr, input logic [31:0] alu,
                       input logic [2:0] lt);
    mem_to_wb_valid = 1'b1;
    mem_reg_we      = we;
    mem_reg_addr    = addr;
    mem_alu_result  = alu;
    mem_load_type   = lt;
    mem_pc          = 32'h1c00_0000 | {alu[29:0], 2'b00};
  endtask

  // Capture one instruction, then leave MEM empty; returns in the cycle it occupies WB.
  task automatic send(input logic we, input logic [4:0] addr, input logic [31:0] alu,
                      input logic [2:0] lt);
    drive(we, addr, alu, lt);
    tick();
    mem_to_wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive(1'b1, 5'd7, 32'h0000_00aa, LD_NONE);
    tick();
    tick();
    #1;
    checks++; if (rf_w_en !== 1'b0) begin errors++; $display("FAIL reset_wen got=%b exp=0", rf_w_en); end
    checks++; if (wb_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin got=%b exp=1", wb_allowin); end
    checks++; if (wb_fwd_valid !== 1'b0) begin errors++; $display("FAIL reset_fwd got=%b exp=0", wb_fwd_valid); end
    checks++; if (rf_w_addr !== 5'd0 || rf_w_data !== 32'd0) begin
      errors++; $display("FAIL reset_port addr=%0d data=%h exp 0/0", rf_w_addr, rf_w_data); end
    resetn = 1'b1;
    tick();
    mem_to_wb_valid = 1'b0;
    #1;
    checks++; if (rf_w_en !== 1'b1 || rf_w_addr !== 5'd7 || rf_w_data !== 32'haa) begin
      errors++; $display("FAIL first_write en=%b addr=%0d data=%h exp 1/7/000000aa", rf_w_en, rf_w_addr, rf_w_data); end
    tick();
  endtask

  task automatic test_alu_write();
    send(1'b1, 5'd5, 32'h1234_5678, LD_NONE);
    #1;
    checks++; if (rf_w_en !== 1'b1 || rf_w_addr !== 5'd5 || rf_w_data !== 32'h1234_5678) begin
      errors++; $display("FAIL alu_write en=%b addr=%0d data=%h exp 1/5/12345678", rf_w_en, rf_w_addr, rf_w_data); end
    checks++; if (wb_fwd_valid !== 1'b1 || wb_fwd_addr !== 5'd5 || wb_fwd_data !== 32'h1234_5678) begin
      errors++; $display("FAIL alu_fwd v=%b addr=%0d data=%h exp 1/5/12345678", wb_fwd_valid, wb_fwd_addr, wb_fwd_data); end
    tick();
    checks++; if (rf_w_en !== 1'b0) begin errors++; $display("FAIL alu_single_write got=%b exp=0", rf_w_en); end
  endtask

  task automatic test_loads();
    logic [2:0]  lt  [8] = '{LD_LB, LD_LBU, LD_LH, LD_LHU, LD_LW, LD_LB, LD_LHU, 3'd6};
    logic [1:0]  al  [8] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0, 2'd1, 2'd3, 2'd2};
    logic [31:0] exp [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01,
                             32'h80FF_7F01, 32'h0000_007F, 32'h0000_80FF, 32'h0000_1002};
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 5'd3, 32'h0000_1000 | {30'd0, al[i]}, lt[i]);
      data_sram_rdata = 32'h80FF_7F01;
      #1;
      checks++; if (rf_w_data !== exp[i] || rf_w_en !== 1'b1) begin
        errors++; $display("FAIL load_%0d type=%0d off=%0d data=%h en=%b exp %h/1", i, lt[i], al[i], rf_w_data, rf_w_en, exp[i]); end
      tick();
      data_sram_rdata = 32'h0;
    end
  endtask

  task automatic test_zero_reg();
    send(1'b1, 5'd0, 32'h0000_dead, LD_NONE);
    #1;
    checks++; if (rf_w_en !== 1'b0 || wb_fwd_valid !== 1'b0) begin
      errors++; $display("FAIL r0_target en=%b fwd=%b exp 0/0", rf_w_en, wb_fwd_valid); end
    tick();
    send(1'b0, 5'd9, 32'h0000_beef, LD_NONE);
    #1;
    checks++; if (rf_w_en !== 1'b0 || wb_fwd_valid !== 1'b0) begin
      errors++; $display("FAIL no_we en=%b fwd=%b exp 0/0", rf_w_en, wb_fwd_valid); end
    tick();
  endtask

  task automatic test_stall();
    int writes = 0;
    send(1'b1, 5'd10, 32'h0000_0055, LD_NONE);
    wb_stall = 1'b1;
    drive(1'b1, 5'd11, 32'h0000_0066, LD_NONE);
    for (int c = 0; c < 3; c++) begin
      #1;
      if (rf_w_en === 1'b1) writes++;
      checks++; if (wb_allowin !== 1'b0 || wb_fwd_valid !== 1'b1 || wb_fwd_addr !== 5'd10) begin
        errors++; $display("FAIL stall_cyc%0d allowin=%b fwd=%b faddr=%0d exp 0/1/10", c, wb_allowin, wb_fwd_valid, wb_fwd_addr); end
      tick();
    end
    checks++; if (writes != 0) begin errors++; $display("FAIL stall_no_write got=%0d exp=0", writes); end
    wb_stall = 1'b0;
    #1;
    checks++; if (rf_w_en !== 1'b1 || rf_w_addr !== 5'd10 || rf_w_data !== 32'h55 || wb_allowin !== 1'b1) begin
      errors++; $display("FAIL stall_release en=%b addr=%0d data=%h allowin=%b exp 1/10/00000055/1", rf_w_en, rf_w_addr, rf_w_data, wb_allowin); end
    tick();
    mem_to_wb_valid = 1'b0;
    #1;
    checks++; if (rf_w_en !== 1'b1 || rf_w_addr !== 5'd11 || rf_w_data !== 32'h66) begin
      errors++; $display("FAIL stall_next en=%b addr=%0d data=%h exp 1/11/00000066", rf_w_en, rf_w_addr, rf_w_data); end
    tick();
  endtask

  task automatic test_flush();
    send(1'b1, 5'd12, 32'h0000_0077, LD_NONE);
    wb_flush = 1'b1;
    drive(1'b1, 5'd13, 32'h0000_0088, LD_NONE);
    #1;
    checks++; if (rf_w_en !== 1'b0 || wb_allowin !== 1'b1) begin
      errors++; $display("FAIL flush_kill en=%b allowin=%b exp 0/1", rf_w_en, wb_allowin); end
    tick();
    wb_flush = 1'b0;
    mem_to_wb_valid = 1'b0;
    #1;
    checks++; if (rf_w_en !== 1'b1 || rf_w_addr !== 5'd13 || rf_w_data !== 32'h88) begin
      errors++; $display("FAIL flush_capture en=%b addr=%0d data=%h exp 1/13/00000088", rf_w_en, rf_w_addr, rf_w_data); end
    tick();
    checks++; if (rf_w_en !== 1'b0) begin errors++; $display("FAIL flush_drain got=%b exp=0", rf_w_en); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(i + 1), 32'h100 + 32'(i * 'h11), LD_NONE);
      #1;
      checks++; if (wb_allowin !== 1'b1) begin errors++; $display("FAIL b2b_allowin%0d got=%b exp=1", i, wb_allowin); end
      if (i > 0) begin
        checks++; if (rf_w_en !== 1'b1 || rf_w_addr !== 5'(i) || rf_w_data !== 32'h100 + 32'((i - 1) * 'h11)) begin
          errors++; $display("FAIL b2b_write%0d en=%b addr=%0d data=%h exp 1/%0d/%h", i, rf_w_en, rf_w_addr, rf_w_data, i, 32'h100 + 32'((i - 1) * 'h11)); end
      end
      tick();
    end
    mem_to_wb_valid = 1'b0;
    #1;
    checks++; if (rf_w_en !== 1'b1 || rf_w_addr !== 5'd4 || rf_w_data !== 32'h133) begin
      errors++; $display("FAIL b2b_last en=%b addr=%0d data=%h exp 1/4/00000133", rf_w_en, rf_w_addr, rf_w_data); end
    tick();
  endtask

  task automatic test_reset_stall();
    send(1'b1, 5'd14, 32'h0000_0099, LD_NONE);
    wb_stall = 1'b1;
    tick();
    resetn = 1'b0;
    #1;
    checks++; if (rf_w_en !== 1'b0) begin errors++; $display("FAIL rststall_hold got=%b exp=0", rf_w_en); end
    tick();
    resetn = 1'b1;
    wb_stall = 1'b0;
    #1;
    checks++; if (rf_w_en !== 1'b0 || wb_fwd_valid !== 1'b0) begin
      errors++; $display("FAIL rststall_discard en=%b fwd=%b exp 0/0", rf_w_en, wb_fwd_valid); end
    tick();
  endtask

  initial begin
    resetn = 1'b0;
    mem_to_wb_valid = 1'b0;
    mem_pc = '0;
    mem_reg_we = 1'b0;
    mem_reg_addr = '0;
    mem_alu_result = '0;
    mem_load_type = LD_NONE;
    data_sram_rdata = '0;
    wb_stall = 1'b0;
    wb_flush = 1'b0;
    #1;
    test_reset();
    test_alu_write();
    test_loads();
    test_zero_reg();
    test_stall();
    test_flush();
    test_back_to_back();
    test_reset_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
